wr_pps_monitor: RTL and testbench

Validates the PPS from the White Rabbit core. It sits directly downstream of the WR core wrapper and consumes its `pps_o` and `clk_sys_o`. Each PPS edge is checked against a nominal clock count, a lock state machine is maintained, and a clean one-cycle `pps_o` is produced. A flywheel pulse covers missing PPS edges for a bounded holdover time. Seconds, period and error counters are exported for software registers.

---
 rtl/wr_pps_monitor_if.sv | 22 ++
 rtl/wr_pps_monitor.sv | 144 ++++++++++++++
 tb/tb_wr_pps_monitor.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/wr_pps_monitor_if.sv
// rtl/wr_pps_monitor_if.sv - PPS input/clear and status/counter bundle for wr_pps_monitor
interface wr_pps_monitor_if;
  logic        pps_i;
  logic        clr_i;
  logic        pps_o;
  logic [31:0] seconds_o;
  logic [31:0] period_o;
  logic [15:0] missing_cnt_o;
  logic [15:0] early_cnt_o;
  logic [1:0]  state_o;
  logic        locked_o;

  modport master (
    output pps_i, clr_i,
    input  pps_o, seconds_o, period_o, missing_cnt_o, early_cnt_o, state_o, locked_o
  );

  modport slave (
    input  pps_i, clr_i,
    output pps_o, seconds_o, period_o, missing_cnt_o, early_cnt_o, state_o, locked_o
  );
endinterface

// File: rtl/wr_pps_monitor.sv
// rtl/wr_pps_monitor.sv - WR PPS validator: period check, lock FSM, flywheel holdover, counters
module wr_pps_monitor #(
  parameter logic [31:0] NOMINAL_CLKS = 32'd62500000,
  parameter logic [31:0] TOL_CLKS     = 32'd100,
  parameter logic [15:0] LOCK_COUNT   = 16'd3,
  parameter logic [15:0] HOLDOVER_MAX = 16'd10
) (
  input logic             clk_sys_i,
  input logic             reset_i,
  wr_pps_monitor_if.slave mon
);
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  localparam logic [31:0] LO_CLKS = NOMINAL_CLKS - TOL_CLKS;
  localparam logic [31:0] HI_CLKS = NOMINAL_CLKS + TOL_CLKS;

  state_t      state, state_n;
  logic        pps_d;
  logic [31:0] cnt, cnt_n, cnt_inc;
  logic [15:0] good_run, good_run_n;
  logic [15:0] hold, hold_n;
  logic        pulse, miss_inc, early_inc;
  logic        edge_det, good, early, timeout, tick;

  assign edge_det = mon.pps_i & ~pps_d;
  assign cnt_inc  = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  assign good     = edge_det && (cnt >= LO_CLKS) && (cnt <= HI_CLKS);
  assign early    = edge_det && (cnt < LO_CLKS);
  assign timeout  = !edge_det && (cnt == HI_CLKS);
  assign tick     = !edge_det && (cnt == NOMINAL_CLKS);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt_inc;
    good_run_n = good_run;
    hold_n     = hold;
    pulse      = 1'b0;
    miss_inc   = 1'b0;
    early_inc  = 1'b0;
    case (state)
      UNLOCKED: begin
        if (edge_det) begin
          cnt_n      = 32'd1;
          good_run_n = 16'd0;
          state_n    = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (good) begin
          cnt_n      = 32'd1;
          good_run_n = good_run + 16'd1;
          if (good_run + 16'd1 >= LOCK_COUNT) begin
            state_n = LOCKED;
            pulse   = 1'b1;
          end
        end else if (early) begin
          cnt_n      = 32'd1;
          good_run_n = 16'd0;
          early_inc  = 1'b1;
        end else if (timeout) begin
          miss_inc = 1'b1;
          state_n  = UNLOCKED;
        end
      end
      LOCKED: begin
        if (good) begin
          pulse = 1'b1;
          cnt_n = 32'd1;
        end else if (early) begin
          early_inc = 1'b1;
        end else if (timeout) begin
          // Restart at TOL+1 so later flywheel ticks land on the ideal second boundary.
          pulse    = 1'b1;
          miss_inc = 1'b1;
          cnt_n    = TOL_CLKS + 32'd1;
          hold_n   = 16'd1;
          state_n  = HOLDOVER;
        end
      end
      HOLDOVER: begin
        if (good) begin
          pulse   = 1'b1;
          cnt_n   = 32'd1;
          state_n = LOCKED;
        end else if (edge_det) begin
          early_inc = 1'b1;
        end else if (tick) begin
          miss_inc = 1'b1;
          if (hold < HOLDOVER_MAX) begin
            pulse  = 1'b1;
            cnt_n  = 32'd1;
            hold_n = hold + 16'd1;
          end else begin
            state_n = UNLOCKED;
          end
        end
      end
      default: state_n = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= UNLOCKED;
      pps_d             <= 1'b0;
      cnt               <= 32'd0;
      good_run          <= 16'd0;
      hold              <= 16'd0;
      mon.pps_o         <= 1'b0;
      mon.locked_o      <= 1'b0;
      mon.seconds_o     <= 32'd0;
      mon.period_o      <= 32'd0;
      mon.missing_cnt_o <= 16'd0;
      mon.early_cnt_o   <= 16'd0;
    end else begin
      state        <= state_n;
      pps_d        <= mon.pps_i;
      cnt          <= cnt_n;
      good_run     <= good_run_n;
      hold         <= hold_n;
      mon.pps_o    <= pulse;
      mon.locked_o <= (state_n == LOCKED);
      if (edge_det) mon.period_o <= cnt;
      if (mon.clr_i) begin
        mon.seconds_o     <= 32'd0;
        mon.missing_cnt_o <= 16'd0;
        mon.early_cnt_o   <= 16'd0;
      end else begin
        if (pulse) mon.seconds_o <= mon.seconds_o + 32'd1;
        if (miss_inc && mon.missing_cnt_o != 16'hFFFF)
          mon.missing_cnt_o <= mon.missing_cnt_o + 16'd1;
        if (early_inc && mon.early_cnt_o != 16'hFFFF)
          mon.early_cnt_o <= mon.early_cnt_o + 16'd1;
      end
    end
  end

  assign mon.state_o = state;
endmodule

// File: tb/tb_wr_pps_monitor.sv
// tb/tb_wr_pps_monitor.sv - Directed bench for wr_pps_monitor (NOMINAL 100, TOL 2, LOCK 3, HOLDOVER 4)
module tb_wr_pps_monitor;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  wr_pps_monitor_if mon();

  wr_pps_monitor #(
    .NOMINAL_CLKS(32'd100),
    .TOL_CLKS    (32'd2),
    .LOCK_COUNT  (16'd3),
    .HOLDOVER_MAX(16'd4)
  ) dut (
    .clk_sys_i(clk),
    .reset_i  (rst),
    .mon      (mon)
  );

  typedef struct {
    int gap;
    int clr;
    int pps;
    int state;
    int sec;
    int period;
    int miss;
    int early;
  } vec_t;

  vec_t vecs[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pps"},     int'(mon.pps_o), 0);
    chk({tag, ".locked"},  int'(mon.locked_o), 0);
    chk({tag, ".state"},   int'(mon.state_o), 0);
    chk({tag, ".seconds"}, int'(mon.seconds_o), 0);
    chk({tag, ".period"},  int'(mon.period_o), 0);
    chk({tag, ".missing"}, int'(mon.missing_cnt_o), 0);
    chk({tag, ".early"},   int'(mon.early_cnt_o), 0);
  endtask

  // pps_i stays high until two cycles before the target, so each edge follows a multi-cycle high level.
  task automatic edge_at(input int target, input int clr);
    while (cyc < target - 2) step();
    mon.pps_i = 1'b0;
    step();
    mon.pps_i = 1'b1;
    mon.clr_i = (clr != 0);
    step();
    mon.clr_i = 1'b0;
  endtask

  initial begin
    int last;
    int k;
    int exp_pps;

    vecs[0] = '{20,  0, 0, 1, 0, 19,  0, 0};
    vecs[1] = '{100, 0, 0, 1, 0, 100, 0, 0};
    vecs[2] = '{100, 0, 0, 1, 0, 100, 0, 0};
    vecs[3] = '{100, 0, 1, 2, 1, 100, 0, 0};
    vecs[4] = '{98,  0, 1, 2, 2, 98,  0, 0};
    vecs[5] = '{102, 0, 1, 2, 3, 102, 0, 0};
    vecs[6] = '{97,  0, 0, 2, 3, 97,  0, 1};
    vecs[7] = '{3,   0, 1, 2, 4, 100, 0, 1};
    vecs[8] = '{100, 1, 1, 2, 0, 100, 0, 0};
    vecs[9] = '{100, 0, 1, 2, 1, 100, 0, 0};

    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    mon.pps_i = 1'b0;
    mon.clr_i = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    rst  = 1'b0;
    last = cyc;

    for (int i = 0; i < 10; i++) begin
      last += vecs[i].gap;
      edge_at(last, vecs[i].clr);
      chk($sformatf("v%0d.pps", i),     int'(mon.pps_o), vecs[i].pps);
      chk($sformatf("v%0d.state", i),   int'(mon.state_o), vecs[i].state);
      chk($sformatf("v%0d.locked", i),  int'(mon.locked_o), (vecs[i].state == 2) ? 1 : 0);
      chk($sformatf("v%0d.seconds", i), int'(mon.seconds_o), vecs[i].sec);
      chk($sformatf("v%0d.period", i),  int'(mon.period_o), vecs[i].period);
      chk($sformatf("v%0d.missing", i), int'(mon.missing_cnt_o), vecs[i].miss);
      chk($sformatf("v%0d.early", i),   int'(mon.early_cnt_o), vecs[i].early);
      step();
      chk($sformatf("v%0d.pps_width", i), int'(mon.pps_o), 0);
    end

    // Flywheel: timeout at +102, ticks on the ideal boundaries, drop lock at the fifth missed second.
    mon.pps_i = 1'b0;
    while (cyc < last + 510) begin
      step();
      k = cyc - last;
      exp_pps = (k == 102 || k == 200 || k == 300 || k == 400) ? 1 : 0;
      chk($sformatf("fly.pps@%0d", k), int'(mon.pps_o), exp_pps);
      if (k == 101) chk("fly.state_locked", int'(mon.state_o), 2);
      if (k == 102 || k == 499) chk($sformatf("fly.state_holdover@%0d", k), int'(mon.state_o), 3);
      if (k == 500) chk("fly.state_unlocked", int'(mon.state_o), 0);
    end
    chk("fly.missing", int'(mon.missing_cnt_o), 5);
    chk("fly.seconds", int'(mon.seconds_o), 5);
    chk("fly.early", int'(mon.early_cnt_o), 0);

    // Relock, enter holdover, then recover with an edge 99 cycles after a flywheel tick.
    last = cyc + 10;
    edge_at(last, 0);
    chk("relock.state_acquire", int'(mon.state_o), 1);
    for (int i = 0; i < 3; i++) begin
      last += 100;
      edge_at(last, 0);
    end
    chk("relock.pps", int'(mon.pps_o), 1);
    chk("relock.locked", int'(mon.locked_o), 1);
    chk("relock.seconds", int'(mon.seconds_o), 6);
    mon.pps_i = 1'b0;
    while (cyc < last + 320) begin
      step();
      k = cyc - last;
      exp_pps = (k == 102 || k == 200 || k == 299) ? 1 : 0;
      chk($sformatf("recover.pps@%0d", k), int'(mon.pps_o), exp_pps);
      if (k == 250) chk("recover.state_holdover", int'(mon.state_o), 3);
      if (k == 299) chk("recover.state_locked", int'(mon.state_o), 2);
      if (k == 298) mon.pps_i = 1'b1;
      if (k == 300) mon.pps_i = 1'b0;
    end
    chk("recover.seconds", int'(mon.seconds_o), 9);
    chk("recover.missing", int'(mon.missing_cnt_o), 7);
    chk("recover.period", int'(mon.period_o), 99);
    chk("recover.early", int'(mon.early_cnt_o), 0);

    // Asynchronous reset while in holdover; no pulses afterwards without relock.
    while (cyc < last + 450) begin
      step();
      k = cyc - last;
      if (k == 401) chk("hold2.pps", int'(mon.pps_o), 1);
      if (k == 401) chk("hold2.state", int'(mon.state_o), 3);
    end
    rst = 1'b1;
    #2;
    chk_zero("async_reset");
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      chk($sformatf("post_reset.pps@%0d", i), int'(mon.pps_o), 0);
    end
    chk("post_reset.state", int'(mon.state_o), 0);
    chk("post_reset.seconds", int'(mon.seconds_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
